// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered ALU with valid/ready handshakes on both sides. It
//            accepts one operation per input handshake and presents the
//            result and its Zero/Overflow/Illegal flags until the consumer
//            takes them. SRA and SLTU are included, and an optional
//            unsigned shift-add multiplier can be compiled in.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   ALU_SEQ_MUL_EN - when defined, opcode 10 is an iterative unsigned MUL
//                    that takes DATA_WIDTH cycles in EXEC. When undefined,
//                    opcode 10 is reported as illegal.
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operation request valid
//   in_ready   out  block can accept an operation
//   src1       in   operand 1
//   src2       in   operand 2 / shift amount (low SHAMT_WIDTH bits)
//   ALUType    in   opcode
//   out_valid  out  result valid
//   out_ready  in   consumer accepts the result
//   alu_result out  registered result
//   Zero       out  alu_result == 0
//   Overflow   out  signed overflow (ADD/SUB), high half nonzero (MUL)
//   Illegal    out  opcode undefined
// ============================================================================
module alu_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    input  logic [OP_WIDTH-1:0]   ALUType,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  Zero,
    output logic                  Overflow,
    output logic                  Illegal
);

    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
    localparam int c_MSB       = DATA_WIDTH - 1;

    localparam logic [OP_WIDTH-1:0] c_OP_ADD  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] c_OP_SUB  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] c_OP_SLL  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] c_OP_SLT  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] c_OP_XOR  = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] c_OP_SRL  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] c_OP_OR   = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] c_OP_AND  = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] c_OP_SRA  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] c_OP_SLTU = OP_WIDTH'(9);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HOLD = 2'd2;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [OP_WIDTH-1:0] c_OP_MUL = OP_WIDTH'(10);
    localparam logic [1:0]          c_EXEC   = 2'd1;
    localparam logic [SHAMT_WIDTH-1:0] c_LAST = SHAMT_WIDTH'(DATA_WIDTH - 1);
`endif

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic                  r_ovf;
    logic                  r_ill;

    logic [DATA_WIDTH-1:0]  w_sum;
    logic [DATA_WIDTH-1:0]  w_diff;
    logic [SHAMT_WIDTH-1:0] w_shamt;
    logic [DATA_WIDTH-1:0]  w_res;
    logic                   w_ovf;
    logic                   w_ill;
    logic                   w_accept;

    assign w_sum    = src1 + src2;
    assign w_diff   = src1 - src2;
    assign w_shamt  = src2[SHAMT_WIDTH-1:0];
    assign w_accept = in_valid && in_ready;

    // Single-cycle datapath evaluated on the live operands; its outputs are
    // captured on the accepting edge, which gives the one-cycle latency.
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (ALUType)
            c_OP_ADD: begin
                w_res = w_sum;
                w_ovf = (src1[c_MSB] == src2[c_MSB]) && (w_sum[c_MSB] != src1[c_MSB]);
            end
            c_OP_SUB: begin
                w_res = w_diff;
                w_ovf = (src1[c_MSB] != src2[c_MSB]) && (w_diff[c_MSB] != src1[c_MSB]);
            end
            c_OP_SLL:  w_res = src1 << w_shamt;
            c_OP_SLT:  w_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
            c_OP_XOR:  w_res = src1 ^ src2;
            c_OP_SRL:  w_res = src1 >> w_shamt;
            c_OP_OR:   w_res = src1 | src2;
            c_OP_AND:  w_res = src1 & src2;
            c_OP_SRA:  w_res = $signed(src1) >>> w_shamt;
            c_OP_SLTU: w_res = {{(DATA_WIDTH-1){1'b0}}, (src1 < src2)};
            // MUL never takes this path when the multiplier is built, so
            // leaving it here makes opcode 10 illegal in the default build.
            default:   w_ill = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // Shift-add multiplier: the multiplicand moves left and the multiplier
    // right, one bit per cycle, into a double-width accumulator.
    logic [2*DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0]   r_mplier;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [SHAMT_WIDTH-1:0]  r_cnt;
    logic [2*DATA_WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                c_IDLE, c_HOLD: begin
                    if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
                        if (ALUType == c_OP_MUL) begin
                            r_state  <= c_EXEC;
                            r_mcand  <= {{DATA_WIDTH{1'b0}}, src1};
                            r_mplier <= src2;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                        end else
`endif
                        begin
                            r_state  <= c_HOLD;
                            r_result <= w_res;
                            r_zero   <= (w_res == '0);
                            r_ovf    <= w_ovf;
                            r_ill    <= w_ill;
                        end
                    end else if ((r_state == c_HOLD) && out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                c_EXEC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + SHAMT_WIDTH'(1);
                    // The last iteration writes the result straight from the
                    // adder so HOLD is entered DATA_WIDTH cycles after accept.
                    if (r_cnt == c_LAST) begin
                        r_state  <= c_HOLD;
                        r_result <= w_acc_next[DATA_WIDTH-1:0];
                        r_zero   <= (w_acc_next[DATA_WIDTH-1:0] == '0);
                        r_ovf    <= (w_acc_next[2*DATA_WIDTH-1:DATA_WIDTH] != '0);
                        r_ill    <= 1'b0;
                    end
                end
`endif
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // In HOLD the slot frees up exactly when the consumer takes the result,
    // which allows a new operation on the same edge.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (r_state == c_IDLE) || ((r_state == c_HOLD) && out_ready);
        end
    end

    assign out_valid  = (r_state == c_HOLD);
    assign alu_result = r_result;
    assign Zero       = r_zero;
    assign Overflow   = r_ovf;
    assign Illegal    = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Directed self-checking bench for alu_seq (DATA_WIDTH=32).
//            Expected values are hand-computed constants. The MUL vectors
//            are compiled only when ALU_SEQ_MUL_EN is defined; otherwise
//            opcode 10 is checked as illegal.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ALUType;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        Zero;
    logic        Overflow;
    logic        Illegal;

    int n_vec = 0;
    int n_mis = 0;

    alu_seq #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .src1       (src1),
        .src2       (src2),
        .ALUType    (ALUType),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .Zero       (Zero),
        .Overflow   (Overflow),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns so sampling is off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] flags();
        return {29'b0, Zero, Overflow, Illegal};
    endfunction

    // Issue one single-cycle op from IDLE with out_ready high, check the
    // result one cycle after accept, then let the block drain back to IDLE.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic [2:0] exp_f);
        src1 = a; src2 = b; ALUType = op;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, ".result"}, alu_result, exp_r);
        check({tag, ".flags"}, flags(), {29'b0, exp_f});
        tick();
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_r, input logic [2:0] exp_f);
        int n;
        src1 = a; src2 = b; ALUType = 4'd10;
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        do begin
            tick();
            in_valid = 1'b0;
            n++;
        end while (!out_valid && n < 100);
        check({tag, ".latency"}, n, 32'd33);
        check({tag, ".result"}, alu_result, exp_r);
        check({tag, ".flags"}, flags(), {29'b0, exp_f});
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        src1 = '0; src2 = '0; ALUType = '0;

        // Reset state (flags in Zero/Overflow/Illegal order)
        #2;
        check("rst.valid", {31'b0, out_valid}, 32'd0);
        check("rst.result", alu_result, 32'd0);
        check("rst.flags", flags(), 32'd0);
        check("rst.in_ready", {31'b0, in_ready}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rel.in_ready", {31'b0, in_ready}, 32'd1);

        // Arithmetic, compare, logic and shift vectors
        run_op("add_ovf",  4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b010);
        run_op("add_wrap", 4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 3'b100);
        run_op("sub",      4'd1, 32'd10,       32'd20,       32'hFFFFFFF6, 3'b000);
        run_op("sub_ovf",  4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 3'b010);
        run_op("slt_neg",  4'd3, 32'hFFFFFFF9, 32'h00000000, 32'h00000001, 3'b000);
        run_op("sltu",     4'd9, 32'hFFFFFFF9, 32'h00000000, 32'h00000000, 3'b100);
        run_op("slt_pos",  4'd3, 32'h0000000E, 32'h00000007, 32'h00000000, 3'b100);
        run_op("sra",      4'd8, 32'hFFFFFFF5, 32'h00000081, 32'hFFFFFFFA, 3'b000);
        run_op("srl",      4'd5, 32'hFFFFFFF5, 32'h00000081, 32'h7FFFFFFA, 3'b000);
        run_op("sll",      4'd2, 32'h000000CC, 32'h000000AA, 32'h00033000, 3'b000);
        run_op("sll_zero", 4'd2, 32'h12345678, 32'h00000020, 32'h12345678, 3'b000);
        run_op("and",      4'd7, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 3'b000);
        run_op("ill_op",   4'd11, 32'h00000005, 32'h00000003, 32'h00000000, 3'b101);
`ifndef ALU_SEQ_MUL_EN
        run_op("op10_ill", 4'd10, 32'h00010000, 32'h00010000, 32'h00000000, 3'b101);
`endif

        // Backpressure: XOR held for 3 cycles, then back-to-back OR accept
        src1 = 32'd1; src2 = 32'd1; ALUType = 4'd4;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp.valid", {31'b0, out_valid}, 32'd1);
            check("bp.result", alu_result, 32'd0);
            check("bp.flags", flags(), 32'b100);
            check("bp.in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        src1 = 32'h5; src2 = 32'hA; ALUType = 4'd6;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b.in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("b2b.valid", {31'b0, out_valid}, 32'd1);
        check("b2b.result", alu_result, 32'h0000000F);
        check("b2b.flags", flags(), 32'd0);
        tick();
        check("b2b.idle", {31'b0, out_valid}, 32'd0);

        // Reset while a result is held
        src1 = 32'h3; src2 = 32'h4; ALUType = 4'd0;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_hold.valid", {31'b0, out_valid}, 32'd0);
        check("rst_hold.result", alu_result, 32'd0);
        check("rst_hold.in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_hold.rel", {31'b0, in_ready}, 32'd1);
        run_op("post_rst", 4'd0, 32'd3, 32'd4, 32'd7, 3'b000);

`ifdef ALU_SEQ_MUL_EN
        run_mul("mul_big", 32'h00010000, 32'h00010000, 32'h00000000, 3'b110);
        run_mul("mul_small", 32'd3, 32'd5, 32'd15, 3'b000);

        // Reset in the middle of a multiply
        src1 = 32'd7; src2 = 32'd9; ALUType = 4'd10;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rst_mul.in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mul.valid", {31'b0, out_valid}, 32'd0);
        check("rst_mul.flags", flags(), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_mul.rel", {31'b0, in_ready}, 32'd1);
        run_mul("mul_after_rst", 32'd7, 32'd9, 32'd63, 3'b000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational ALU.
- Accepts one operation per valid/ready handshake and returns a registered result with Zero/Overflow/Illegal flags on an output valid/ready handshake.
- Adds SRA and SLTU, plus an optional iterative multiplier.
- Sits between the decode/issue stage and writeback; supports output backpressure.

Parameters:
DATA_WIDTH, 32, operand/result width (>=8, power of two)
OP_WIDTH, 4, width of ALUType
SHAMT_WIDTH, $clog2(DATA_WIDTH), derived localparam: shift amount = src2[SHAMT_WIDTH-1:0]

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept operation
src1  input  DATA_WIDTH  operand 1
src2  input  DATA_WIDTH  operand 2 / shift amount
ALUType  input  OP_WIDTH  opcode
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
alu_result  output  DATA_WIDTH  registered result
Zero  output  1  alu_result == 0
Overflow  output  1  signed overflow (ADD/SUB); unsigned high-half nonzero (MUL)
Illegal  output  1  opcode undefined

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 XOR, 5 SRL, 6 OR, 7 AND, 8 SRA, 9 SLTU, 10 MUL (only with macro).
- All other opcodes: alu_result=0, Zero=1, Overflow=0, Illegal=1, normal single-cycle latency.
- SLT/SLTU: result is 1 or 0, zero-extended.
- Overflow is 0 for all ops except ADD/SUB/MUL.
- FSM states:
  - IDLE: in_ready=1.
  - EXEC: MUL iteration, in_ready=0.
  - HOLD: out_valid=1.
- Accept: in_valid && in_ready on a rising edge latches src1, src2 and ALUType.
  - Single-cycle op: IDLE -> HOLD. out_valid rises the cycle after accept (latency 1).
  - MUL: -> EXEC, then DATA_WIDTH iterations, then HOLD (latency DATA_WIDTH+1).
- HOLD:
  - alu_result and all flags stable until out_ready=1.
  - in_ready = out_ready (combinational), so back-to-back accept is allowed.
  - On out_ready: if in_valid, accept the new op (next state per op); else go to IDLE.
  - Sustained throughput: 1 op/cycle for single-cycle ops.
- EXEC: in_valid is ignored; out_ready is ignored.
- Reset (async, any state, including mid-MUL):
  - State = IDLE; multiplier counter/accumulator cleared.
  - out_valid=0, alu_result=0, Zero=0, Overflow=0, Illegal=0.
  - in_ready=0 while rst=1; in_ready=1 in the first cycle after release.
- Arithmetic: results truncated to DATA_WIDTH (wrap-around).
  - ADD overflow: operand signs equal and result sign differs.
  - SUB overflow: operand signs differ and result sign differs from src1.
- Shifts: only the low SHAMT_WIDTH bits of src2 are used; a shift by 0 passes src1 through unchanged.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - Opcode 10 = unsigned iterative shift-add MUL, one bit per cycle, DATA_WIDTH cycles in EXEC.
  - alu_result = low half of the product; Overflow=1 if the high half is nonzero.
- Undefined:
  - No EXEC state or multiplier logic is compiled.
  - Opcode 10 is treated as illegal (result 0, Zero=1, Illegal=1, latency 1).

Test Plan:
- Reset: rst=1 mid-stream, including during a MUL in EXEC -> out_valid=0, alu_result=0, all flags 0, in_ready=0; after release, in_ready=1 and the next op completes normally.
- ADD 0x7FFFFFFF+0x1 -> 0x80000000, Overflow=1, Zero=0, out_valid one cycle after accept. SUB 10-20 -> 0xFFFFFFF6, Overflow=0.
- SLT src1=0xFFFFFFF9, src2=0 -> 1. SLTU with the same operands -> 0. SLT 0xE,0x7 -> 0.
- SRA 0xFFFFFFF5 by src2=0x81 (shamt 1) -> 0xFFFFFFFA. SRL same -> 0x7FFFFFFA. SLL 0xCC by 0xAA (shamt 10) -> 0x00033000.
- Backpressure:
  - XOR 1,1 with out_ready=0 for 3 cycles -> result 0, Zero=1 held stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 (OR 0x5,0xA) -> accepted the same cycle; next result 0xF.
- Opcode 10 with 0x10000*0x10000:
  - Macro defined: out_valid 33 cycles after accept, result 0, Overflow=1; 3*5 -> 15, Overflow=0.
  - Macro undefined: Illegal=1 at latency 1.
